// File: rtl/sram_arbiter.sv
// Two-master SRAM arbiter: m0 (CPU, read/write) and m1 (video/DMA, read-only)
// share one synchronous SRAM port. Each transaction runs IDLE -> ACCESS
// (WAIT_STATES+1 cycles) -> DONE, with the ready pulse issued in DONE.
// Ties in IDLE are resolved round-robin; defining SRAM_ARB_M1_PRIORITY_EN
// switches tie-breaking to fixed priority with m1 always winning.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        sram_ce,
  output logic [16:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_rdata,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wstrb_q;
  logic        pick_m1;
  logic        any_valid;
  logic        unused_addr_hi;

  // Only the low 17 address bits reach the SRAM.
  assign unused_addr_hi = ^{m0_addr[31:17], m1_addr[31:17]};

  assign any_valid = m0_valid | m1_valid;

  // Arbitration: a lone requester wins outright; a tie goes to the policy.
  always_comb begin
    pick_m1 = m1_valid;
    if (m0_valid && m1_valid) begin
`ifdef SRAM_ARB_M1_PRIORITY_EN
      pick_m1 = 1'b1;
`else
      pick_m1 = ~grant;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the granted request, count wait states, capture read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant      <= 1'b1;
      wait_cnt   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      wstrb_q    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant    <= pick_m1;
            wait_cnt <= 4'(WAIT_STATES);
            if (pick_m1) begin
              sram_addr  <= m1_addr[16:0];
              sram_wdata <= '0;
              wstrb_q    <= '0;
            end else begin
              sram_addr  <= m0_addr[16:0];
              sram_wdata <= m0_wdata;
              wstrb_q    <= m0_wstrb;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (grant) begin
            m1_rdata <= sram_rdata;
          end else begin
            m0_rdata <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; ready only ever goes to the granted master.
  always_comb begin
    sram_ce    = (state == ACCESS);
    sram_wstrb = (state == ACCESS) ? wstrb_q : '0;
    m0_ready   = (state == DONE) && !grant;
    m1_ready   = (state == DONE) && grant;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: table-driven single transactions,
// hand-written sequences for ties, reset mid-access and valid drop, plus a
// WAIT_STATES=0 instance. Completions are checked through a scoreboard queue.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0;
  logic [31:0] m1_addr = '0;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        sram_ce;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_rdata = '0;
  logic        grant;

  logic        z_m0_valid = 1'b0;
  logic [31:0] z_m0_addr = '0;
  logic        z_m0_ready;
  logic [31:0] z_m0_rdata;
  logic        z_m1_ready;
  logic [31:0] z_m1_rdata;
  logic        z_sram_ce;
  logic [16:0] z_sram_addr;
  logic [31:0] z_sram_wdata;
  logic [3:0]  z_sram_wstrb;
  logic [31:0] z_sram_rdata = '0;
  logic        z_grant;

  sram_arbiter #(.WAIT_STATES(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata), .grant(grant)
  );

  sram_arbiter #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .resetn(resetn),
    .m0_valid(z_m0_valid), .m0_addr(z_m0_addr), .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_ready(z_m0_ready), .m0_rdata(z_m0_rdata),
    .m1_valid(1'b0), .m1_addr(32'h0), .m1_ready(z_m1_ready), .m1_rdata(z_m1_rdata),
    .sram_ce(z_sram_ce), .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata),
    .sram_wstrb(z_sram_wstrb), .sram_rdata(z_sram_rdata), .grant(z_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd;
    logic [16:0] exp_addr;
    logic [3:0]  exp_wstrb;
  } vec_t;

  typedef struct {
    logic        m;
    logic [31:0] rd;
    int          lat;
    int          gap;
    int          start;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_rdy = 0;
  logic [31:0] last_m0 = '0;
  logic [31:0] last_m1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Cycle counter, advanced on every rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completion monitor: every ready pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resetn && (m0_ready || m1_ready)) begin
      chk("ready_exclusive", {31'b0, m0_ready & m1_ready}, 32'd0);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b expected none (cycle %0d)",
                 m0_ready, m1_ready, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ready_master", {31'b0, m1_ready}, {31'b0, e.m});
        chk("grant_at_ready", {31'b0, grant}, {31'b0, e.m});
        chk("rdata", e.m ? m1_rdata : m0_rdata, e.rd);
        if (e.lat > 0) chk("latency", 32'(cyc - e.start), 32'(e.lat));
        if (e.gap > 0) chk("ready_spacing", 32'(cyc - last_rdy), 32'(e.gap));
      end
      last_rdy = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn   = 1'b0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(posedge clk); #1;
    resetn  = 1'b1;
    last_m0 = '0;
    last_m1 = '0;
  endtask

  task automatic wait_ready(input logic m, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = m ? m1_ready : m0_ready;
    end
    if (!seen) timeout(name);
  endtask

  task automatic wait_ce(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = sram_ce;
    end
    if (!seen) timeout(name);
  endtask

  task automatic run_vec(input vec_t v);
    int ce_n = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    sram_rdata = v.rd;
    if (v.m) begin
      m1_valid = 1'b1;
      m1_addr  = v.addr;
    end else begin
      m0_valid = 1'b1;
      m0_addr  = v.addr;
      m0_wdata = v.wdata;
      m0_wstrb = v.wstrb;
    end
    sbq.push_back('{m: v.m, rd: v.rd, lat: 4, gap: 0, start: cyc});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sram_ce) begin
        ce_n++;
        chk("sram_addr", {15'b0, sram_addr}, {15'b0, v.exp_addr});
        chk("sram_wstrb", {28'b0, sram_wstrb}, {28'b0, v.exp_wstrb});
        if (!v.m && v.wstrb != 4'h0) chk("sram_wdata", sram_wdata, v.wdata);
      end
      seen = v.m ? m1_ready : m0_ready;
    end
    if (!seen) timeout("vec_ready");
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    chk("ce_cycles", 32'(ce_n), 32'd3);
    if (v.m) last_m1 = v.rd;
    else     last_m0 = v.rd;
    chk("m0_rdata_hold", m0_rdata, last_m0);
    chk("m1_rdata_hold", m1_rdata, last_m1);
  endtask

  initial begin
    int   n;
    int   start;
    int   ce_n;
    bit   seen;
    logic any_rdy;

    //            m     addr          wdata         wstrb  rd            exp_addr   exp_wstrb
    vecs[0] = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 17'h00100, 4'hF};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 32'h1234_5678, 17'h00100, 4'h0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 17'h1FFFC, 4'h0};
    vecs[3] = '{1'b0, 32'h0001_2344, 32'h1122_3344, 4'h3, 32'h0000_0000, 17'h12344, 4'h3};
    vecs[4] = '{1'b1, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h0BAD_CAFE, 17'h00040, 4'h0};
    vecs[5] = '{1'b0, 32'h0002_0000, 32'h0000_0000, 4'h0, 32'h55AA_55AA, 17'h00000, 4'h0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_ce", {31'b0, sram_ce}, 32'd0);
    chk("rst_sram_wstrb", {28'b0, sram_wstrb}, 32'd0);
    chk("rst_sram_addr", {15'b0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_readies", {30'b0, m0_ready, m1_ready}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_grant", {31'b0, grant}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Tie after reset: both masters request continuously.
    do_reset();
    @(posedge clk); #1;
    sram_rdata = 32'hA5A5_5A5A;
    m0_addr    = 32'h0000_0300;
    m0_wstrb   = 4'h0;
    m1_addr    = 32'h0000_0400;
`ifdef SRAM_ARB_M1_PRIORITY_EN
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 4, gap: 0, start: cyc});
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
`else
    sbq.push_back('{m: 1'b0, rd: 32'hA5A5_5A5A, lat: 4, gap: 0, start: cyc});
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
    sbq.push_back('{m: 1'b0, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
    sbq.push_back('{m: 1'b1, rd: 32'hA5A5_5A5A, lat: 0, gap: 5, start: 0});
`endif
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) n++;
    end
    if (n < 4) timeout("tie_readies");
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    // Reset during the second ACCESS cycle aborts the transaction.
    @(posedge clk); #1;
    m0_valid = 1'b1;
    m0_addr  = 32'h0000_0200;
    m0_wdata = 32'h1357_2468;
    m0_wstrb = 4'hF;
    wait_ce("abort_ce");
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn   = 1'b1;
    m0_valid = 1'b0;
    last_m0  = '0;
    last_m1  = '0;
    @(negedge clk);
    chk("abort_sram_ce", {31'b0, sram_ce}, 32'd0);
    chk("abort_readies", {30'b0, m0_ready, m1_ready}, 32'd0);
    chk("abort_grant", {31'b0, grant}, 32'd1);
    chk("abort_sram_wstrb", {28'b0, sram_wstrb}, 32'd0);
    any_rdy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_rdy = any_rdy | m0_ready | m1_ready;
    end
    chk("abort_no_ready", {31'b0, any_rdy}, 32'd0);
    run_vec(vecs[0]);

    // m1 drops valid mid-access; a pending m0 follows right after.
    @(posedge clk); #1;
    sram_rdata = 32'h7777_0001;
    m1_valid   = 1'b1;
    m1_addr    = 32'h0000_0080;
    sbq.push_back('{m: 1'b1, rd: 32'h7777_0001, lat: 4, gap: 0, start: cyc});
    wait_ce("drop_ce");
    @(posedge clk); #1;
    m1_valid = 1'b0;
    m0_valid = 1'b1;
    m0_addr  = 32'h0000_0090;
    m0_wstrb = 4'h0;
    sbq.push_back('{m: 1'b0, rd: 32'h8888_0002, lat: 0, gap: 5, start: 0});
    wait_ready(1'b1, "drop_m1_ready");
    @(posedge clk); #1;
    sram_rdata = 32'h8888_0002;
    wait_ready(1'b0, "drop_m0_ready");
    @(posedge clk); #1;
    m0_valid = 1'b0;
    chk("drop_m1_rdata", m1_rdata, 32'h7777_0001);
    chk("drop_m0_rdata", m0_rdata, 32'h8888_0002);

    // WAIT_STATES=0 instance: single ACCESS cycle, ready two cycles after valid.
    @(posedge clk); #1;
    z_sram_rdata = 32'h0F0F_1234;
    z_m0_addr    = 32'h0000_0044;
    z_m0_valid   = 1'b1;
    start = cyc;
    ce_n  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (z_sram_ce) ce_n++;
      if (z_m0_ready) begin
        seen = 1'b1;
        chk("ws0_latency", 32'(cyc - start), 32'd2);
        chk("ws0_rdata", z_m0_rdata, 32'h0F0F_1234);
      end
    end
    if (!seen) timeout("ws0_ready");
    @(posedge clk); #1;
    z_m0_valid = 1'b0;
    chk("ws0_ce_cycles", 32'(ce_n), 32'd1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, SRAM access cycles beyond the first (range 0..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port m0_valid, input, 1, CPU request; held until m0_ready.
REQ-005 SHALL have port m0_addr, input, 32, CPU byte address.
REQ-006 SHALL have port m0_wdata, input, 32, CPU write data.
REQ-007 SHALL have port m0_wstrb, input, 4, CPU byte strobes; 0 means read.
REQ-008 SHALL have port m0_ready, output, 1, one-cycle completion pulse to CPU.
REQ-009 SHALL have port m0_rdata, output, 32, CPU read data, valid while m0_ready=1.
REQ-010 SHALL have port m1_valid, input, 1, video/DMA read request; held until m1_ready.
REQ-011 SHALL have port m1_addr, input, 32, video/DMA byte address; read-only requester.
REQ-012 SHALL have port m1_ready, output, 1, one-cycle completion pulse to video/DMA.
REQ-013 SHALL have port m1_rdata, output, 32, video/DMA read data, valid while m1_ready=1.
REQ-014 SHALL have port sram_ce, output, 1, SRAM enable, high only in ACCESS.
REQ-015 SHALL have port sram_addr, output, 17, latched granted address bits [16:0].
REQ-016 SHALL have port sram_wdata, output, 32, latched granted write data.
REQ-017 SHALL have port sram_wstrb, output, 4, latched strobes in ACCESS; 0 otherwise.
REQ-018 SHALL have port sram_rdata, input, 32, SRAM read data.
REQ-019 SHALL have port grant, output, 1, current/last owner: 0=m0, 1=m1.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE.
- IDLE→ACCESS: when any valid.
- ACCESS→DONE: when wait counter = 0.
- DONE→IDLE: unconditionally.
REQ-021 SHALL, on leaving IDLE, latch addr, wdata and wstrb of the granted master, update grant, and load the wait counter with WAIT_STATES.
- m1 strobes forced to 0.
REQ-022 SHALL arbitrate round-robin on a tie: both valid in IDLE grants the master not granted last; a single valid master is granted directly.
REQ-023 SHALL decrement the wait counter each ACCESS cycle while nonzero.
- ACCESS lasts WAIT_STATES+1 cycles.
REQ-024 SHALL capture sram_rdata into the granted master's rdata register on the last ACCESS cycle, and assert that master's ready for exactly the DONE cycle.
REQ-025 SHALL give a latency from valid sampled in IDLE to ready high of WAIT_STATES+2 cycles.
- Example: 4 cycles at default.
REQ-026 SHALL never assert m0_ready and m1_ready together, nor assert ready to a non-granted master.
REQ-027 SHALL complete an in-flight transaction even if its valid drops mid-access, including the ready pulse.
- Requests arriving during ACCESS/DONE wait until IDLE.
REQ-028 SHALL hold rdata outputs stable between captures; the non-granted rdata is unchanged.
REQ-029 SHALL require one IDLE cycle between transactions.
- Back-to-back throughput: one transfer per WAIT_STATES+3 cycles.

Reset
REQ-030 SHALL, when resetn=0 at a clock edge, force:
- state IDLE, counter 0, grant=1 (m0 wins the first tie);
- sram_ce=0, sram_wstrb=0, sram_addr=0, sram_wdata=0;
- m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0.
REQ-031 SHALL abort any transaction on reset mid-operation, with no ready pulse issued for it.

Configuration
REQ-032 SHALL, with macro SRAM_ARB_M1_PRIORITY_EN defined, replace round-robin with fixed priority: m1 wins every tie.
- Without the macro, REQ-022 applies.
- Latency and state behaviour are otherwise identical.

Verification
REQ-033 Single CPU write:
- Stimulus: m0 addr 0x0000_0100, wdata 0xDEADBEEF, wstrb 0xF.
- Required: sram_ce high for 3 cycles with sram_addr 0x00100 and sram_wstrb 0xF; m0_ready pulses 4 cycles after valid.
REQ-034 CPU read:
- Stimulus: sram_rdata=0x12345678.
- Required: m0_rdata=0x12345678 during the m0_ready cycle; sram_wstrb stays 0.
REQ-035 Tie after reset:
- Stimulus: m0 and m1 both valid continuously.
- Required: grant sequence 0,1,0,1; each ready exactly once per grant, spaced 5 cycles.
- With SRAM_ARB_M1_PRIORITY_EN defined: m1 granted every time.
REQ-036 WAIT_STATES=0:
- Required: one-cycle ACCESS; ready 2 cycles after valid.
REQ-037 Reset mid-operation:
- Stimulus: resetn=0 during the second ACCESS cycle.
- Required: next cycle sram_ce=0, no ready, grant=1; a new m0 request then completes normally.
REQ-038 m1 valid drops during ACCESS:
- Required: m1_ready still pulses once; a pending m0 is granted the following IDLE cycle.
